// File: rtl/fmul16_rsh_round.sv
// Right-shift (subnormal result) rounding stage for the F16 multiplier:
// two-stage valid/ready pipeline producing rounded fraction, exponent and flags.

module fmul16_rsh_lgs_mask #(
  parameter int TW = 11
) (
  input  logic [21:0]   sig_i,
  input  logic [4:0]    pos_i,
  output logic          l_o,
  output logic          g_o,
  output logic          s_o,
  output logic [TW-1:0] trunc_o
);
  logic [31:0] ext_s;
  logic [31:0] low_mask_s;

  // Zero-extend so indices above 21 read as 0; pos_i is always >= 10.
  always_comb begin
    ext_s      = {10'd0, sig_i};
    low_mask_s = (32'd1 << (pos_i - 5'd1)) - 32'd1;
    l_o        = ext_s[pos_i];
    g_o        = ext_s[pos_i - 5'd1];
    s_o        = |(ext_s & low_mask_s);
    trunc_o    = TW'(ext_s >> pos_i);
  end
endmodule

module fmul16_rsh_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [21:0] sig_mul_i,
  input  logic [3:0]  rsh_num_i,
  input  logic        sign_i,
  input  logic [2:0]  rm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        sign_o,
  output logic [4:0]  exp_o,
  output logic [9:0]  frac_o,
  output logic        inexact_o,
  output logic        underflow_o
);
  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  function automatic logic round_up(input rm_e rm, input logic sgn,
                                    input logic l, input logic g, input logic s);
    logic up;
    case (rm)
      RM_RNE:  up = g & (l | s);
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = sgn & (g | s);
      RM_RUP:  up = ~sgn & (g | s);
      RM_RMM:  up = g;
      default: up = 1'b0;
    endcase
    return up;
  endfunction

  logic [3:0]  r_s;
  logic [4:0]  pos_s, pos_uf_s;
  logic        l_s, g_s, s_s, lu_s, gu_s, su_s;
  logic [10:0] trunc_s;
  logic [11:0] trunc_uf_s;
  rm_e         rm_dec_s;

  // Shift amount 0 behaves as 1; out-of-range modes fall back to RNE.
  always_comb begin
    r_s      = (rsh_num_i == 4'd0) ? 4'd1 : rsh_num_i;
    pos_s    = 5'd10 + {1'b0, r_s};
    pos_uf_s = 5'd9 + {1'b0, r_s};
    case (rm_i)
      3'd0:    rm_dec_s = RM_RNE;
      3'd1:    rm_dec_s = RM_RTZ;
      3'd2:    rm_dec_s = RM_RDN;
      3'd3:    rm_dec_s = RM_RUP;
      3'd4:    rm_dec_s = RM_RMM;
      default: rm_dec_s = RM_RNE;
    endcase
  end

  fmul16_rsh_lgs_mask #(.TW(11)) u_mask_main (
    .sig_i(sig_mul_i), .pos_i(pos_s),
    .l_o(l_s), .g_o(g_s), .s_o(s_s), .trunc_o(trunc_s)
  );

  fmul16_rsh_lgs_mask #(.TW(12)) u_mask_uf (
    .sig_i(sig_mul_i), .pos_i(pos_uf_s),
    .l_o(lu_s), .g_o(gu_s), .s_o(su_s), .trunc_o(trunc_uf_s)
  );

  logic        s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic        s1_l_q, s1_l_d, s1_g_q, s1_g_d, s1_s_q, s1_s_d;
  logic        s1_lu_q, s1_lu_d, s1_gu_q, s1_gu_d, s1_su_q, s1_su_d;
  logic [10:0] s1_trunc_q, s1_trunc_d;
  logic [11:0] s1_trunc_uf_q, s1_trunc_uf_d;
  logic        s1_sign_q, s1_sign_d;
  rm_e         s1_rm_q, s1_rm_d;
  logic        sign_q, sign_d, inexact_q, inexact_d, underflow_q, underflow_d;
  logic [4:0]  exp_q, exp_d;
  logic [9:0]  frac_q, frac_d;
  logic        s2_ready_s, s1_load_s, s2_load_s, rup_s, rup_uf_s;
  logic [10:0] rounded_s;
  logic [12:0] rounded_uf_s;

  // Handshake and next-state for both stages; data moves only on load.
  always_comb begin
    s2_ready_s   = ~s2_vld_q | out_ready_i;
    in_ready_o   = ~s1_vld_q | s2_ready_s;
    s1_load_s    = in_valid_i & in_ready_o;
    s2_load_s    = s1_vld_q & s2_ready_s;
    rup_s        = round_up(s1_rm_q, s1_sign_q, s1_l_q, s1_g_q, s1_s_q);
    rup_uf_s     = round_up(s1_rm_q, s1_sign_q, s1_lu_q, s1_gu_q, s1_su_q);
    rounded_s    = s1_trunc_q + {10'd0, rup_s};
    rounded_uf_s = {1'b0, s1_trunc_uf_q} + {12'd0, rup_uf_s};

    s1_l_d = s1_l_q; s1_g_d = s1_g_q; s1_s_d = s1_s_q;
    s1_lu_d = s1_lu_q; s1_gu_d = s1_gu_q; s1_su_d = s1_su_q;
    s1_trunc_d = s1_trunc_q; s1_trunc_uf_d = s1_trunc_uf_q;
    s1_sign_d = s1_sign_q; s1_rm_d = s1_rm_q;
    sign_d = sign_q; exp_d = exp_q; frac_d = frac_q;
    inexact_d = inexact_q; underflow_d = underflow_q;

    if (s1_load_s) begin
      s1_vld_d      = 1'b1;
      s1_l_d        = l_s;
      s1_g_d        = g_s;
      s1_s_d        = s_s;
      s1_lu_d       = lu_s;
      s1_gu_d       = gu_s;
      s1_su_d       = su_s;
      s1_trunc_d    = trunc_s;
      s1_trunc_uf_d = trunc_uf_s;
      s1_sign_d     = sign_i;
      s1_rm_d       = rm_dec_s;
    end else if (s2_load_s) begin
      s1_vld_d = 1'b0;
    end else begin
      s1_vld_d = s1_vld_q;
    end

    if (s2_load_s) begin
      s2_vld_d    = 1'b1;
      sign_d      = s1_sign_q;
      exp_d       = {4'b0, rounded_s[10]};
      frac_d      = rounded_s[9:0];
      inexact_d   = s1_g_q | s1_s_q;
      // Tiny when rounding at one position finer still stays below 2^11.
      underflow_d = (rounded_uf_s < 13'd2048) & (s1_g_q | s1_s_q);
    end else if (out_ready_i) begin
      s2_vld_d = 1'b0;
    end else begin
      s2_vld_d = s2_vld_q;
    end
  end

  // Pipeline registers with synchronous reset clearing all state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0; s2_vld_q <= 1'b0;
      s1_l_q <= 1'b0; s1_g_q <= 1'b0; s1_s_q <= 1'b0;
      s1_lu_q <= 1'b0; s1_gu_q <= 1'b0; s1_su_q <= 1'b0;
      s1_trunc_q <= 11'd0; s1_trunc_uf_q <= 12'd0;
      s1_sign_q <= 1'b0; s1_rm_q <= RM_RNE;
      sign_q <= 1'b0; exp_q <= 5'd0; frac_q <= 10'd0;
      inexact_q <= 1'b0; underflow_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d; s2_vld_q <= s2_vld_d;
      s1_l_q <= s1_l_d; s1_g_q <= s1_g_d; s1_s_q <= s1_s_d;
      s1_lu_q <= s1_lu_d; s1_gu_q <= s1_gu_d; s1_su_q <= s1_su_d;
      s1_trunc_q <= s1_trunc_d; s1_trunc_uf_q <= s1_trunc_uf_d;
      s1_sign_q <= s1_sign_d; s1_rm_q <= s1_rm_d;
      sign_q <= sign_d; exp_q <= exp_d; frac_q <= frac_d;
      inexact_q <= inexact_d; underflow_q <= underflow_d;
    end
  end

  // Outputs come straight from stage-2 flops.
  always_comb begin
    out_valid_o = s2_vld_q;
    sign_o      = sign_q;
    exp_o       = exp_q;
    frac_o      = frac_q;
    inexact_o   = inexact_q;
    underflow_o = underflow_q;
  end
endmodule

// File: tb/tb_fmul16_rsh_round.sv
// Directed and randomized self-checking bench for fmul16_rsh_round.

module tb_fmul16_rsh_round;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [21:0] sig_mul;
  logic [3:0]  rsh_num;
  logic        sign_in;
  logic [2:0]  rm;
  logic        sign_o, inexact_o, underflow_o;
  logic [4:0]  exp_o;
  logic [9:0]  frac_o;
  int          total = 0;
  int          bad = 0;

  fmul16_rsh_round dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sig_mul_i(sig_mul), .rsh_num_i(rsh_num), .sign_i(sign_in), .rm_i(rm),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sign_o(sign_o), .exp_o(exp_o), .frac_o(frac_o),
    .inexact_o(inexact_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] obs();
    return {sign_o, exp_o, frac_o, inexact_o, underflow_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference: remainder compared against the half-ulp at each shift position.
  function automatic logic ref_rup(input int mode, input logic sgn, input longint trunc,
                                   input longint rem, input longint half);
    logic g, s, l;
    g = (rem >= half);
    s = g ? (rem != half) : (rem != 0);
    l = trunc[0];
    if (mode == 1) return 1'b0;
    if (mode == 2) return sgn & (g | s);
    if (mode == 3) return !sgn & (g | s);
    if (mode == 4) return g;
    return g & (l | s);
  endfunction

  function automatic logic [17:0] ref_model(input logic [21:0] sig, input logic [3:0] rsh,
                                            input logic sgn, input logic [2:0] mode);
    int r, sh;
    longint v, t, rem, t2, rem2, rnd, rnd2;
    logic inx, uf;
    r = (rsh == 4'd0) ? 1 : int'(rsh);
    v = longint'(sig);
    sh = 10 + r;
    t = v >> sh;
    rem = v - (t << sh);
    rnd = t + longint'(ref_rup(int'(mode), sgn, t, rem, 64'd1 << (sh - 1)));
    t2 = v >> (sh - 1);
    rem2 = v - (t2 << (sh - 1));
    rnd2 = t2 + longint'(ref_rup(int'(mode), sgn, t2, rem2, 64'd1 << (sh - 2)));
    inx = (rem != 0);
    uf = inx && (rnd2 < 2048);
    return {sgn, 4'd0, rnd[10], rnd[9:0], inx, uf};
  endfunction

  task automatic send(input logic [21:0] sig, input logic [3:0] rsh, input logic sgn,
                      input logic [2:0] mode, output logic [17:0] res, output int lat);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    sig_mul = sig; rsh_num = rsh; sign_in = sgn; rm = mode;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; res = 18'd0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i; res = obs();
        break;
      end
    end
  endtask

  logic [17:0] res, ea, eb, ec, exp_v;
  int          lat;
  logic [17:0] q[$];
  int          sent, got;
  logic        seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sig_mul = 22'd0; rsh_num = 4'd0; sign_in = 1'b0; rm = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_outs", {14'd0, obs()}, 32'd0);
    chk("reset_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;

    send(22'h000C00, 4'd1, 1'b0, 3'd0, res, lat);
    chk("rne_tie", res, {1'b0, 5'd0, 10'h002, 1'b1, 1'b1});
    chk("latency", lat, 2);
    send(22'h000C00, 4'd1, 1'b0, 3'd1, res, lat);
    chk("rtz_tie", res, {1'b0, 5'd0, 10'h001, 1'b1, 1'b1});
    send(22'h1FFC00, 4'd1, 1'b0, 3'd0, res, lat);
    chk("carry_tiny", res, {1'b0, 5'd1, 10'h000, 1'b1, 1'b1});
    send(22'h1FFE00, 4'd1, 1'b0, 3'd0, res, lat);
    chk("carry_not_tiny", res, {1'b0, 5'd1, 10'h000, 1'b1, 1'b0});
    send(22'h200000, 4'd15, 1'b0, 3'd3, res, lat);
    chk("r15_rup", res, {1'b0, 5'd0, 10'h001, 1'b1, 1'b1});
    send(22'h200000, 4'd15, 1'b0, 3'd2, res, lat);
    chk("r15_rdn_pos", res, {1'b0, 5'd0, 10'h000, 1'b1, 1'b1});
    send(22'h200000, 4'd15, 1'b1, 3'd2, res, lat);
    chk("r15_rdn_neg", res, {1'b1, 5'd0, 10'h001, 1'b1, 1'b1});
    send(22'h000C00, 4'd0, 1'b0, 3'd0, res, lat);
    chk("rsh0_as_1", res, {1'b0, 5'd0, 10'h002, 1'b1, 1'b1});
    send(22'h200000, 4'd12, 1'b0, 3'd0, res, lat);
    chk("r12_rne", res, {1'b0, 5'd0, 10'h000, 1'b1, 1'b1});
    send(22'h200000, 4'd12, 1'b0, 3'd4, res, lat);
    chk("r12_rmm", res, {1'b0, 5'd0, 10'h001, 1'b1, 1'b1});
    send(22'h000400, 4'd1, 1'b0, 3'd4, res, lat);
    chk("rmm_half", res, {1'b0, 5'd0, 10'h001, 1'b1, 1'b1});
    send(22'h000400, 4'd1, 1'b0, 3'd5, res, lat);
    chk("rm5_as_rne", res, {1'b0, 5'd0, 10'h000, 1'b1, 1'b1});
    send(22'h000800, 4'd1, 1'b0, 3'd0, res, lat);
    chk("exact", res, {1'b0, 5'd0, 10'h001, 1'b0, 1'b0});
    send(22'h3FFFFF, 4'd13, 1'b1, 3'd2, res, lat);
    chk("r13_rdn_neg", res, {1'b1, 5'd0, 10'h001, 1'b1, 1'b1});
    send(22'h300000, 4'd11, 1'b0, 3'd0, res, lat);
    chk("r11_rne", res, {1'b0, 5'd0, 10'h002, 1'b1, 1'b1});

    // Backpressure: three back-to-back beats against a stalled output.
    ea = {1'b0, 5'd0, 10'h002, 1'b1, 1'b1};
    eb = {1'b0, 5'd1, 10'h000, 1'b1, 1'b0};
    ec = {1'b0, 5'd0, 10'h001, 1'b0, 1'b0};
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1;
    sig_mul = 22'h000C00; rsh_num = 4'd1; sign_in = 1'b0; rm = 3'd0;
    #1 chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    sig_mul = 22'h1FFE00;
    #1 chk("bp_ready2", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    sig_mul = 22'h000800;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
      chk("bp_valid_held", {31'd0, out_valid}, 32'd1);
      chk("bp_data_held", obs(), ea);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_out_a", obs(), ea);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out_b_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_out_b", obs(), eb);
    @(negedge clk);
    chk("bp_out_c_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_out_c", obs(), ec);
    @(negedge clk);
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Reset with two beats in flight.
    out_ready = 1'b0; in_valid = 1'b1; sig_mul = 22'h1FFE00;
    @(negedge clk);
    sig_mul = 22'h000C00;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outs", {14'd0, obs()}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("rst_no_stale", {31'd0, seen}, 32'd0);

    // Random traffic with random downstream ready against the reference model.
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20000 && got < 3000; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 3000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        sig_mul = ($urandom_range(0, 3) == 0) ? 22'($urandom_range(0, 4095)) : 22'($urandom);
        rsh_num = 4'($urandom_range(0, 15));
        sign_in = 1'($urandom_range(0, 1));
        rm = 3'($urandom_range(0, 7));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rand_unexpected", 32'd1, 32'd0);
        end else begin
          exp_v = q.pop_front();
          chk("rand_beat", obs(), exp_v);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_model(sig_mul, rsh_num, sign_in, rm));
        sent++;
      end
    end
    in_valid = 1'b0;
    chk("rand_count", got, 3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
